debug_scan_slave: RTL and testbench
===================================

// Module: debug_scan_slave
// PURPOSE
//  Parametrised single-clock debug scan slave. Replaces the fixed 2-bit-IR / 38-bit-DR debug slave.
//  Sits between the virtual-JTAG strobe synchroniser and the CPU debug logic (break/ocimem/trace units).
//  Shifts capture data out and host data in, checks scan length, and issues one-hot action requests
//  to NUM_CH channels with a valid/ready handshake. Reports overrun and short-scan status through ir_out.
// PARAMETERS
//  IR_W    2   instruction register width; channel index = latched IR
//  SR_W    38  scan (data) register width
//  NUM_CH  4   number of action channels, 1..2**IR_W
// PORTS
//  clk          in   1            system clock
//  reset_n      in   1            asynchronous, active-low reset
//  vs_uir       in   1            update-IR strobe, 1-cycle pulse, clk domain
//  vs_cdr       in   1            capture-DR strobe, 1-cycle pulse
//  vs_sdr       in   1            shift-DR strobe, one pulse per bit
//  vs_udr       in   1            update-DR strobe, 1-cycle pulse
//  ir_in        in   IR_W         instruction from host, sampled on vs_uir
//  tdi          in   1            serial data in, sampled with vs_sdr
//  tdo          out  1            serial data out = sr[0]
//  ir_out       out  IR_W         status: [0]=action pending, [1]=overrun|short_scan (IR_W>=2), rest 0
//  cap_data     in   NUM_CH*SR_W  per-channel capture words; channel c = cap_data[c*SR_W +: SR_W]
//  jdo          out  SR_W         last accepted scan word; stable while any act_valid is high
//  act_go       out  1            jdo[SR_W-1]: 1 = take action, 0 = take no action
//  act_valid    out  NUM_CH       one-hot action request, held until accepted
//  act_ready    in   NUM_CH       per-channel accept
//  overrun      out  1            sticky: udr arrived while an action was pending
//  short_scan   out  1            sticky: udr after fewer than SR_W shifts
//  status_clr   in   1            clears overrun and short_scan
// BEHAVIOUR
//  Reset: sr=0, ir_q=0, cnt=0, state=IDLE, jdo=0, act_valid=0, overrun=0, short_scan=0 -> tdo=0, ir_out=0.
//  FSM states: IDLE, SHIFT.
//   - vs_uir (any state): ir_q<=ir_in; state->IDLE. A scan in progress is aborted and no action is issued.
//   - vs_cdr (any state): sr<=cap word of ir_q (0 if ir_q>=NUM_CH); cnt<=0; state->SHIFT.
//   - vs_sdr in SHIFT: sr<={tdi,sr[SR_W-1:1]}; cnt saturates at SR_W. Ignored in IDLE.
//   - vs_udr in SHIFT: state->IDLE; outcome is the first matching rule:
//     ir_q>=NUM_CH -> no effect; cnt<SR_W -> short_scan<=1; any act_valid -> overrun<=1, word dropped;
//     else jdo<=sr, act_valid[ir_q]<=1.
//     Ignored in IDLE.
//  Strobe priority if several coincide in one cycle: uir > cdr > udr > sdr; only the winner acts.
//  Latency: udr in cycle N -> act_valid/jdo visible in N+1. tdo is updated one cycle after each sdr.
//  Handshake: act_valid[c] drops the cycle after act_valid[c]&act_ready[c]. act_ready is ignored when not valid.
//   - A udr arriving in the accept cycle still counts as overrun.
//   - A new request may be issued from the cycle after the drop.
//  status_clr coinciding with a new set event: set wins.
//  Async reset mid-scan or mid-handshake returns all registers to reset values immediately.
// STRUCTURE
//  Package debug_slave_pkg: state enum (IDLE, SHIFT), CNT_W=$clog2(SR_W+1), and ir_out bit-index constants.
//  One sub-module: dbg_scan_sr (SR_W shift register with parallel load and saturating cnt).
//  The FSM, action issue and status logic stay in the top module.
// TESTING (IR_W=2, SR_W=38, NUM_CH=4)
//  1. uir ir=2; cdr with cap[2]=38'h2A_DEAD_BEEF; 38 sdr with tdi=0 -> tdo emits 0x2A_DEADBEEF LSB first.
//  2. uir ir=1; cdr; 38 sdr of 38'h20_0000_0001; udr; act_ready=1 two cycles later.
//     -> act_valid=4'b0010 from udr+1, act_go=1, jdo=38'h20_0000_0001, drop after accept.
//  3. Hold act_ready=0 after case 2 and run a second full scan + udr.
//     -> overrun=1, ir_out=2'b11, jdo unchanged; status_clr -> overrun=0.
//  4. cdr, 37 sdr, udr -> short_scan=1, act_valid=0. Same cycle status_clr and new short scan -> short_scan stays 1.
//  5. Same-cycle uir+udr during SHIFT -> no action, state IDLE.
//     reset_n low mid-shift -> tdo=0, act_valid=0 asynchronously.

Source files
------------

// File: rtl/debug_slave_pkg.sv
// rtl/debug_slave_pkg.sv - shared types and constants for the debug scan slave
package debug_slave_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEF_SR_W = 38;
  localparam int CNT_W    = $clog2(DEF_SR_W + 1);

  localparam int IR_OUT_PEND = 0;
  localparam int IR_OUT_ERR  = 1;

  // Counter width for an arbitrary scan length: must be able to hold SR_W itself.
  function automatic int cnt_width(input int sr_w);
    return $clog2(sr_w + 1);
  endfunction

endpackage

// File: rtl/dbg_scan_sr.sv
// rtl/dbg_scan_sr.sv - scan shift register with parallel capture and saturating bit count
module dbg_scan_sr
  import debug_slave_pkg::*;
#(
  parameter int SR_W  = 38,
  parameter int CNT_W = cnt_width(SR_W)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_i,
  input  logic [SR_W-1:0]  load_data_i,
  input  logic             shift_i,
  input  logic             tdi_i,
  output logic [SR_W-1:0]  sr_o,
  output logic [CNT_W-1:0] cnt_o
);

  logic [SR_W-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (load_i) begin
      sr_d  = load_data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      sr_d = {tdi_i, sr_q[SR_W-1:1]};
      if (cnt_q != CNT_W'(SR_W)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  assign sr_o  = sr_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/debug_scan_slave.sv
// rtl/debug_scan_slave.sv - parametrised debug scan slave: IR/DR scan, length check, one-hot action issue
module debug_scan_slave
  import debug_slave_pkg::*;
#(
  parameter int IR_W   = 2,
  parameter int SR_W   = 38,
  parameter int NUM_CH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   vs_uir,
  input  logic                   vs_cdr,
  input  logic                   vs_sdr,
  input  logic                   vs_udr,
  input  logic [IR_W-1:0]        ir_in,
  input  logic                   tdi,
  output logic                   tdo,
  output logic [IR_W-1:0]        ir_out,
  input  logic [NUM_CH*SR_W-1:0] cap_data,
  output logic [SR_W-1:0]        jdo,
  output logic                   act_go,
  output logic [NUM_CH-1:0]      act_valid,
  input  logic [NUM_CH-1:0]      act_ready,
  output logic                   overrun,
  output logic                   short_scan,
  input  logic                   status_clr
);

  localparam int LCNT_W  = cnt_width(SR_W);
  localparam int ERR_IDX = (IR_W >= 2) ? IR_OUT_ERR : IR_OUT_PEND;

  state_e              state_q;
  logic [IR_W-1:0]     ir_q;
  logic [SR_W-1:0]     jdo_q;
  logic [NUM_CH-1:0]   act_valid_q;
  logic                overrun_q;
  logic                short_scan_q;

  logic [SR_W-1:0]     sr;
  logic [LCNT_W-1:0]   cnt;
  logic [SR_W-1:0]     cap_word;
  logic [NUM_CH-1:0]   ch_sel;
  logic                uir_win, cdr_win, udr_win, sdr_win;
  logic                ch_ok, cnt_full, pending;
  logic                short_set, ovr_set, issue;

  // ch_sel is empty when ir_q names a channel that does not exist.
  always_comb begin
    cap_word = '0;
    ch_sel   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ir_q == IR_W'(c)) begin
        cap_word  = cap_data[c*SR_W +: SR_W];
        ch_sel[c] = 1'b1;
      end
    end
  end

  always_comb begin
    uir_win   = vs_uir;
    cdr_win   = vs_cdr & ~vs_uir;
    udr_win   = vs_udr & ~vs_uir & ~vs_cdr & (state_q == SHIFT);
    sdr_win   = vs_sdr & ~vs_uir & ~vs_cdr & ~vs_udr & (state_q == SHIFT);
    ch_ok     = |ch_sel;
    cnt_full  = (cnt == LCNT_W'(SR_W));
    pending   = |act_valid_q;
    short_set = udr_win & ch_ok & ~cnt_full;
    ovr_set   = udr_win & ch_ok & cnt_full & pending;
    issue     = udr_win & ch_ok & cnt_full & ~pending;
  end

  dbg_scan_sr #(
    .SR_W  (SR_W),
    .CNT_W (LCNT_W)
  ) u_sr (
    .clk         (clk),
    .reset_n     (reset_n),
    .load_i      (cdr_win),
    .load_data_i (cap_word),
    .shift_i     (sdr_win),
    .tdi_i       (tdi),
    .sr_o        (sr),
    .cnt_o       (cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ir_q         <= '0;
      jdo_q        <= '0;
      act_valid_q  <= '0;
      overrun_q    <= 1'b0;
      short_scan_q <= 1'b0;
    end else begin
      if (uir_win) begin
        ir_q    <= ir_in;
        state_q <= IDLE;
      end else if (cdr_win) begin
        state_q <= SHIFT;
      end else if (udr_win) begin
        state_q <= IDLE;
      end

      if (issue) begin
        jdo_q <= sr;
      end
      // Accept clears first; a new request can only be issued when nothing is pending.
      act_valid_q <= (act_valid_q & ~act_ready) | (issue ? ch_sel : '0);

      if (ovr_set) begin
        overrun_q <= 1'b1;
      end else if (status_clr) begin
        overrun_q <= 1'b0;
      end

      if (short_set) begin
        short_scan_q <= 1'b1;
      end else if (status_clr) begin
        short_scan_q <= 1'b0;
      end
    end
  end

  always_comb begin
    ir_out              = '0;
    ir_out[IR_OUT_PEND] = pending;
    if (IR_W >= 2) begin
      ir_out[ERR_IDX] = overrun_q | short_scan_q;
    end
  end

  assign tdo        = sr[0];
  assign jdo        = jdo_q;
  assign act_go     = jdo_q[SR_W-1];
  assign act_valid  = act_valid_q;
  assign overrun    = overrun_q;
  assign short_scan = short_scan_q;

endmodule

// File: tb/tb_debug_scan_slave.sv
// tb/tb_debug_scan_slave.sv - directed self-checking bench for debug_scan_slave
module tb_debug_scan_slave;

  logic         clk;
  logic         reset_n;
  logic         vs_uir, vs_cdr, vs_sdr, vs_udr;
  logic [1:0]   ir_in;
  logic         tdi;
  logic         tdo;
  logic [1:0]   ir_out;
  logic [151:0] cap_data;
  logic [37:0]  jdo;
  logic         act_go;
  logic [3:0]   act_valid;
  logic [3:0]   act_ready;
  logic         overrun;
  logic         short_scan;
  logic         status_clr;

  int checks = 0;
  int errors = 0;

  localparam logic [37:0] CAP2  = 38'h2A_DEAD_BEEF;
  localparam logic [37:0] CAP1  = 38'h00_0000_0005;
  localparam logic [37:0] W_GO  = 38'h20_0000_0001;
  localparam logic [37:0] W_A   = 38'h00_1234_5678;
  localparam logic [37:0] W_B   = 38'h3F_FFFF_FFFF;
  localparam logic [37:0] W_SAT = 38'h3F_0000_000C;
  localparam logic [37:0] W_SAT_EXP = 38'h0F_C000_0003;

  debug_scan_slave #(.IR_W(2), .SR_W(38), .NUM_CH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .vs_uir     (vs_uir),
    .vs_cdr     (vs_cdr),
    .vs_sdr     (vs_sdr),
    .vs_udr     (vs_udr),
    .ir_in      (ir_in),
    .tdi        (tdi),
    .tdo        (tdo),
    .ir_out     (ir_out),
    .cap_data   (cap_data),
    .jdo        (jdo),
    .act_go     (act_go),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .overrun    (overrun),
    .short_scan (short_scan),
    .status_clr (status_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_uir(input logic [1:0] ir);
    vs_uir = 1'b1; ir_in = ir;
    @(negedge clk);
    vs_uir = 1'b0;
  endtask

  task automatic pulse_cdr();
    vs_cdr = 1'b1;
    @(negedge clk);
    vs_cdr = 1'b0;
  endtask

  task automatic pulse_sdr(input logic b);
    vs_sdr = 1'b1; tdi = b;
    @(negedge clk);
    vs_sdr = 1'b0; tdi = 1'b0;
  endtask

  task automatic pulse_udr();
    vs_udr = 1'b1;
    @(negedge clk);
    vs_udr = 1'b0;
  endtask

  task automatic scan(input logic [1:0] ch, input logic [37:0] w, input int n, input bit with_udr);
    pulse_uir(ch);
    pulse_cdr();
    for (int i = 0; i < n; i++) pulse_sdr((i < 38) ? w[i] : 1'b0);
    if (with_udr) pulse_udr();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    vs_uir = 0; vs_cdr = 0; vs_sdr = 0; vs_udr = 0;
    ir_in = 0; tdi = 0; act_ready = 0; status_clr = 0;
    cap_data = '0;
    cap_data[2*38 +: 38] = CAP2;
    cap_data[1*38 +: 38] = CAP1;
    repeat (2) @(negedge clk);
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b exp 0", tdo); end
    checks++; if (ir_out !== 2'b00) begin errors++; $display("FAIL reset_ir_out got %b exp 00", ir_out); end
    checks++; if (act_valid !== 4'b0) begin errors++; $display("FAIL reset_act_valid got %b exp 0000", act_valid); end
    checks++; if (jdo !== 38'h0) begin errors++; $display("FAIL reset_jdo got %h exp 0", jdo); end
    checks++; if ({overrun, short_scan, act_go} !== 3'b000) begin errors++; $display("FAIL reset_status got %b exp 000", {overrun, short_scan, act_go}); end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_capture_shift();
    logic [37:0] got;
    got = '0;
    pulse_uir(2'd2);
    pulse_cdr();
    for (int i = 0; i < 38; i++) begin
      got[i] = tdo;
      pulse_sdr(1'b0);
    end
    checks++; if (got !== CAP2) begin errors++; $display("FAIL capture_tdo_stream got %h exp %h", got, CAP2); end
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL capture_tdo_drained got %b exp 0", tdo); end
  endtask

  task automatic test_action();
    scan(2'd1, W_GO, 38, 1'b1);
    checks++; if (act_valid !== 4'b0010) begin errors++; $display("FAIL action_valid got %b exp 0010", act_valid); end
    checks++; if (jdo !== W_GO) begin errors++; $display("FAIL action_jdo got %h exp %h", jdo, W_GO); end
    checks++; if (act_go !== 1'b1) begin errors++; $display("FAIL action_go got %b exp 1", act_go); end
    checks++; if (ir_out !== 2'b01) begin errors++; $display("FAIL action_ir_out got %b exp 01", ir_out); end
    @(negedge clk);
    checks++; if (act_valid !== 4'b0010) begin errors++; $display("FAIL action_held got %b exp 0010", act_valid); end
    act_ready = 4'b0010;
    @(negedge clk);
    act_ready = 4'b0000;
    checks++; if (act_valid !== 4'b0000) begin errors++; $display("FAIL action_drop got %b exp 0000", act_valid); end
  endtask

  task automatic test_overrun();
    scan(2'd1, W_A, 38, 1'b1);
    checks++; if (act_valid !== 4'b0010) begin errors++; $display("FAIL b2b_valid got %b exp 0010", act_valid); end
    checks++; if ({act_go, jdo} !== {1'b0, W_A}) begin errors++; $display("FAIL b2b_jdo got %h exp %h", jdo, W_A); end
    scan(2'd1, W_B, 38, 1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
    checks++; if (ir_out !== 2'b11) begin errors++; $display("FAIL overrun_ir_out got %b exp 11", ir_out); end
    checks++; if (jdo !== W_A) begin errors++; $display("FAIL overrun_jdo_kept got %h exp %h", jdo, W_A); end
    checks++; if (act_valid !== 4'b0010) begin errors++; $display("FAIL overrun_valid got %b exp 0010", act_valid); end
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clr got %b exp 0", overrun); end
    checks++; if (ir_out !== 2'b01) begin errors++; $display("FAIL overrun_clr_ir_out got %b exp 01", ir_out); end
    act_ready = 4'b1111;
    @(negedge clk);
    act_ready = 4'b0000;
    checks++; if (act_valid !== 4'b0000) begin errors++; $display("FAIL overrun_accept got %b exp 0000", act_valid); end
  endtask

  task automatic test_short_scan();
    scan(2'd1, W_A, 37, 1'b1);
    checks++; if (short_scan !== 1'b1) begin errors++; $display("FAIL short_set got %b exp 1", short_scan); end
    checks++; if (act_valid !== 4'b0000) begin errors++; $display("FAIL short_no_action got %b exp 0000", act_valid); end
    checks++; if (ir_out !== 2'b10) begin errors++; $display("FAIL short_ir_out got %b exp 10", ir_out); end
    scan(2'd1, W_A, 37, 1'b0);
    status_clr = 1'b1; vs_udr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0; vs_udr = 1'b0;
    checks++; if (short_scan !== 1'b1) begin errors++; $display("FAIL short_set_wins got %b exp 1", short_scan); end
    status_clr = 1'b1;
    @(negedge clk);
    status_clr = 1'b0;
    checks++; if (short_scan !== 1'b0) begin errors++; $display("FAIL short_clr got %b exp 0", short_scan); end
    scan(2'd1, W_SAT, 40, 1'b1);
    checks++; if (short_scan !== 1'b0) begin errors++; $display("FAIL sat_no_short got %b exp 0", short_scan); end
    checks++; if (jdo !== W_SAT_EXP) begin errors++; $display("FAIL sat_jdo got %h exp %h", jdo, W_SAT_EXP); end
    checks++; if (act_valid !== 4'b0010) begin errors++; $display("FAIL sat_valid got %b exp 0010", act_valid); end
    act_ready = 4'b0010;
    @(negedge clk);
    act_ready = 4'b0000;
  endtask

  task automatic test_priority_and_reset();
    pulse_uir(2'd1);
    pulse_cdr();
    checks++; if (tdo !== 1'b1) begin errors++; $display("FAIL prio_cap_tdo got %b exp 1", tdo); end
    pulse_sdr(1'b0);
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL prio_shift_tdo got %b exp 0", tdo); end
    vs_uir = 1'b1; ir_in = 2'd1; vs_udr = 1'b1;
    @(negedge clk);
    vs_uir = 1'b0; vs_udr = 1'b0;
    checks++; if ({act_valid, short_scan} !== 5'b0) begin errors++; $display("FAIL prio_uir_wins got %b exp 00000", {act_valid, short_scan}); end
    pulse_sdr(1'b0);
    checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL prio_idle_sdr got %b exp 0", tdo); end
    pulse_udr();
    checks++; if ({act_valid, short_scan} !== 5'b0) begin errors++; $display("FAIL prio_idle_udr got %b exp 00000", {act_valid, short_scan}); end
    scan(2'd1, W_A, 38, 1'b1);
    pulse_cdr();
    checks++; if ({tdo, act_valid} !== 5'b1_0010) begin errors++; $display("FAIL pre_reset got %b exp 10010", {tdo, act_valid}); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({tdo, act_valid} !== 5'b0) begin errors++; $display("FAIL async_reset got %b exp 00000", {tdo, act_valid}); end
    checks++; if (jdo !== 38'h0) begin errors++; $display("FAIL async_reset_jdo got %h exp 0", jdo); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_capture_shift();
    test_action();
    test_overrun();
    test_short_scan();
    test_priority_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
